countdown_timer_ctrl: RTL and testbench

Control block for the mm:ss countdown timer. It owns the minute/second registers and sequences them from three debounced single-cycle button pulses: add minute, start/stop and clear. A prescaler derives the 1 Hz decrement tick from the system clock. Outputs are the BCD display word plus state flags and an alarm that self-terminates.

---
 rtl/countdown_timer_if.sv | 22 ++
 rtl/countdown_timer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Button pulses and display/status outputs of the mm:ss countdown timer.
// The master drives the three button pulses, the slave (the timer) drives the display word and flags.
interface countdown_timer_if;
    logic        btn_add_min;
    logic        btn_start_stop;
    logic        btn_clear;
    logic [15:0] min_sec;
    logic        running;
    logic        paused;
    logic        alarm;
    logic [2:0]  state;

    modport master (
        output btn_add_min, btn_start_stop, btn_clear,
        input  min_sec, running, paused, alarm, state
    );

    modport slave (
        input  btn_add_min, btn_start_stop, btn_clear,
        output min_sec, running, paused, alarm, state
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown timer controller: minute/second registers, 1 Hz prescaler, self-terminating alarm.
//
// state | meaning
// IDLE  | time is 00:00, waiting for the first add-minute
// SET   | minutes being entered, count not started
// RUN   | counting down one second per prescaler tick
// PAUSE | count frozen, prescaler phase held for resume
// ALARM | count reached 00:00, alarm held for ALARM_SEC seconds
module countdown_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SEC     = 5
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    MAX_MIN_V  = 7'(MAX_MIN);
    localparam logic [AW-1:0] ALARM_V    = AW'(ALARM_SEC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          tick;

    function automatic logic [6:0] sat_inc(input logic [6:0] m);
        return (m >= MAX_MIN_V) ? MAX_MIN_V : m + 7'd1;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            presc_q <= '0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
            acnt_q  <= acnt_d;
        end
    end

    // Next-state and datapath update; clear dominates, then start/stop, then add-minute
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        acnt_d  = acnt_q;
        tick    = (presc_q == PRESC_LAST);
        if (bus.btn_clear) begin
            state_d = S_IDLE;
            min_d   = '0;
            sec_d   = '0;
            presc_d = '0;
            acnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.btn_start_stop && bus.btn_add_min) begin
                        min_d   = 7'd1;
                        state_d = S_SET;
                    end
                end
                S_SET: begin
                    if (bus.btn_start_stop) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end else if (bus.btn_add_min) begin
                        min_d = sat_inc(min_q);
                    end
                end
                S_RUN: begin
                    if (bus.btn_start_stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            if (sec_q != 6'd0) begin
                                sec_d = sec_q - 6'd1;
                            end else if (min_q != 7'd0) begin
                                sec_d = 6'd59;
                                min_d = min_q - 7'd1;
                            end
                        end
                        // add-minute saturates after any borrow on the same edge
                        if (bus.btn_add_min) begin
                            min_d = sat_inc(min_d);
                        end
                        if (min_d == 7'd0 && sec_d == 6'd0) begin
                            state_d = S_ALARM;
                            presc_d = '0;
                            acnt_d  = '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.btn_start_stop) begin
                        state_d = S_RUN;
                    end else if (bus.btn_add_min) begin
                        min_d = sat_inc(min_q);
                    end
                end
                S_ALARM: begin
                    if (bus.btn_start_stop) begin
                        state_d = S_IDLE;
                        presc_d = '0;
                        acnt_d  = '0;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            if (acnt_q + AW'(1) == ALARM_V) begin
                                state_d = S_IDLE;
                                acnt_d  = '0;
                            end else begin
                                acnt_d = acnt_q + AW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                    presc_d = '0;
                    acnt_d  = '0;
                end
            endcase
        end
    end

    // Output decode: BCD display word and state flags straight from the registers
    always_comb begin
        bus.min_sec = {4'(min_q / 7'd10), 4'(min_q % 7'd10),
                       4'(sec_q / 6'd10), 4'(sec_q % 6'd10)};
        bus.running = (state_q == S_RUN);
        bus.paused  = (state_q == S_PAUSE);
        bus.alarm   = (state_q == S_ALARM);
        bus.state   = state_q;
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Testbench for countdown_timer_ctrl: directed scenarios followed by randomized episodes,
// every cycle compared against a reference model kept in total-seconds form.
module tb_countdown_timer_ctrl;

    localparam int TPS  = 4;
    localparam int ASEC = 2;
    localparam int MMAX = 99;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_ALARM = 4;

    logic clk;
    logic rst;
    countdown_timer_if bus();

    countdown_timer_ctrl #(
        .TICKS_PER_SEC(TPS),
        .MAX_MIN(MMAX),
        .ALARM_SEC(ASEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;

    // reference model: mode, remaining time in seconds, cycles into current second, alarm cycles left
    int m_mode;
    int m_tot;
    int m_frac;
    int m_aleft;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int add_minute(input int tot);
        int m;
        int s;
        m = tot / 60;
        s = tot % 60;
        m = (m + 1 > MMAX) ? MMAX : m + 1;
        return m * 60 + s;
    endfunction

    function automatic logic [15:0] to_bcd(input int tot);
        int m;
        int s;
        m = tot / 60;
        s = tot % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(input bit add, input bit ss, input bit clr, input bit r);
        if (r || clr) begin
            m_mode = M_IDLE;
            m_tot  = 0;
            m_frac = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (!ss && add) begin
                    m_tot  = 60;
                    m_mode = M_SET;
                end
            end
            M_SET: begin
                if (ss) begin
                    m_mode = M_RUN;
                    m_frac = 0;
                end else if (add) begin
                    m_tot = add_minute(m_tot);
                end
            end
            M_RUN: begin
                if (ss) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_frac++;
                    if (m_frac == TPS) begin
                        m_frac = 0;
                        if (m_tot > 0) m_tot--;
                    end
                    if (add) m_tot = add_minute(m_tot);
                    if (m_tot == 0) begin
                        m_mode  = M_ALARM;
                        m_aleft = ASEC * TPS;
                    end
                end
            end
            M_PAUSE: begin
                if (ss) m_mode = M_RUN;
                else if (add) m_tot = add_minute(m_tot);
            end
            default: begin
                if (ss) begin
                    m_mode = M_IDLE;
                end else begin
                    m_aleft--;
                    if (m_aleft == 0) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] obs_word();
        return {8'h00, bus.min_sec, 1'b0, bus.running, bus.paused, bus.alarm, 1'b0, bus.state};
    endfunction

    function automatic logic [31:0] exp_word();
        logic [15:0] t;
        t = (m_mode == M_IDLE || m_mode == M_ALARM) ? 16'h0000 : to_bcd(m_tot);
        return {8'h00, t, 1'b0, 1'(m_mode == M_RUN), 1'(m_mode == M_PAUSE),
                1'(m_mode == M_ALARM), 1'b0, 3'(m_mode)};
    endfunction

    task automatic cycle(input bit add, input bit ss, input bit clr, input bit r);
        bus.btn_add_min    = add;
        bus.btn_start_stop = ss;
        bus.btn_clear      = clr;
        rst                = r;
        @(posedge clk);
        model_step(add, ss, clr, r);
        #1;
        chk("cyc", obs_word(), exp_word());
        bus.btn_add_min    = 1'b0;
        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        rst                = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_mode = M_IDLE;
        m_tot = 0;
        m_frac = 0;
        m_aleft = 0;
        rst = 1'b1;
        bus.btn_add_min = 1'b0;
        bus.btn_start_stop = 1'b0;
        bus.btn_clear = 1'b0;

        // reset, start with nothing set
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("reset", obs_word(), 32'h0);
        cycle(0, 1, 0, 0);
        chk("idle_ss", obs_word(), 32'h0);

        // two minutes, full countdown, alarm duration
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        chk("start_0200", {16'h0, bus.min_sec}, 32'h0200);
        chk("start_state", {29'h0, bus.state}, 32'd2);
        idle(4);
        chk("first_tick", {16'h0, bus.min_sec}, 32'h0159);
        idle(476);
        chk("end_time", {16'h0, bus.min_sec}, 32'h0000);
        chk("end_state", {29'h0, bus.state}, 32'd4);
        idle(7);
        chk("alarm_7", {31'h0, bus.alarm}, 32'd1);
        idle(1);
        chk("alarm_off", {29'h0, bus.state}, 32'd0);

        // minute saturation
        for (int i = 0; i < 101; i++) cycle(1, 0, 0, 0);
        chk("sat_9900", {16'h0, bus.min_sec}, 32'h9900);
        chk("sat_state", {29'h0, bus.state}, 32'd1);

        // pause and resume keep the prescaler phase
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle(3);
        cycle(0, 1, 0, 0);
        idle(10);
        chk("pause_hold", {16'h0, bus.min_sec}, 32'h0100);
        chk("pause_flag", {31'h0, bus.paused}, 32'd1);
        cycle(0, 1, 0, 0);
        idle(1);
        chk("resume_tick", {16'h0, bus.min_sec}, 32'h0059);

        // add-minute on a borrow tick, clear beats start/stop
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle(3);
        cycle(1, 0, 0, 0);
        chk("borrow_add", {16'h0, bus.min_sec}, 32'h0159);
        cycle(0, 1, 1, 0);
        chk("clr_ss", obs_word(), 32'h0);

        // early alarm acknowledge
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle(240);
        chk("alarm_in", {29'h0, bus.state}, 32'd4);
        cycle(0, 1, 0, 0);
        chk("alarm_ack", {29'h0, bus.state}, 32'd0);

        // reset in RUN at 03:42
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle(72);
        chk("at_0342", {16'h0, bus.min_sec}, 32'h0342);
        cycle(0, 0, 0, 1);
        chk("rst_run", obs_word(), 32'h0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle(3);
        chk("restart_hold", {16'h0, bus.min_sec}, 32'h0100);
        idle(1);
        chk("restart_tick", {16'h0, bus.min_sec}, 32'h0059);

        // randomized episodes
        for (int e = 0; e < 40; e++) begin
            int k;
            cycle(0, 0, 1, 0);
            k = $urandom_range(1, 2);
            for (int i = 0; i < k; i++) cycle(1, 0, 0, 0);
            cycle(0, 1, 0, 0);
            for (int c = 0; c < 600; c++) begin
                bit a, s, cl, r;
                a  = ($urandom_range(0, 399) == 0);
                s  = ($urandom_range(0, 49) == 0);
                cl = ($urandom_range(0, 1999) == 0);
                r  = ($urandom_range(0, 2999) == 0);
                cycle(a, s, cl, r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
